// File: rtl/shift_pkg.sv
// Shared definitions for the iterative right shifter: state encoding and fill helper.
package shift_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_e;

  // Sign fill for arithmetic shifts, zero fill for logical shifts.
  function automatic logic fill_bit(input logic arith, input logic msb);
    return arith & msb;
  endfunction

endpackage

// File: rtl/iter_shift_right_shr_step.sv
// One-position right shift with an explicit fill bit entering at the MSB.
module shr_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  assign dout = {fill, din[WIDTH-1:1]};

endmodule

// File: rtl/iter_shift_right.sv
// Multi-cycle right shifter: one bit position per clock, valid/ready on both sides.
module iter_shift_right
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Extra bit keeps WIDTH == 2**AMT_W from wrapping to zero.
  localparam logic [AMT_W:0]   WIDTH_X = (AMT_W+1)'(WIDTH);
  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_e           state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [AMT_W-1:0] cnt_r, cnt_s;
  logic             fill_r, fill_s;
  logic [WIDTH-1:0] out_data_r, out_data_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic [WIDTH-1:0] step_s;
  logic             in_fill_s;
  logic             in_sat_s;

  shr_step #(.WIDTH(WIDTH)) u_step (
    .din  (sreg_r),
    .fill (fill_r),
    .dout (step_s)
  );

  assign in_fill_s = fill_bit(in_arith, in_data[WIDTH-1]);
  assign in_sat_s  = ({1'b0, in_amt} >= WIDTH_X);

  // Next-state, datapath and result selection.
  always_comb begin
    state_s    = state_r;
    sreg_s     = sreg_r;
    cnt_s      = cnt_r;
    fill_s     = fill_r;
    out_data_s = out_data_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) begin
          fill_s = in_fill_s;
          cnt_s  = in_amt;
          if (in_amt == CNT_ZERO) begin
            sreg_s     = in_data;
            out_data_s = in_data;
            state_s    = S_DONE;
          end else if (in_sat_s) begin
            sreg_s     = {WIDTH{in_fill_s}};
            out_data_s = {WIDTH{in_fill_s}};
            state_s    = S_DONE;
          end else begin
            sreg_s  = in_data;
            state_s = S_SHIFT;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SHIFT: begin
        sreg_s = step_s;
        cnt_s  = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          out_data_s = step_s;
          state_s    = S_DONE;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      sreg_r      <= '0;
      cnt_r       <= '0;
      fill_r      <= 1'b0;
      out_data_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      sreg_r      <= sreg_s;
      cnt_r       <= cnt_s;
      fill_r      <= fill_s;
      out_data_r  <= out_data_s;
      in_ready_r  <= (state_s == S_IDLE);
      out_valid_r <= (state_s == S_DONE);
      busy_r      <= (state_s != S_IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule
